// File: rtl/delay_align_p.sv
// ---------------------------------------------------------------------------
// delay_align_p
//   Focusing-delay stage in front of the channel summer. Each channel's
//   samples go into a circular buffer. On every valid cycle the stage outputs
//   the sample that was written delay[c] samples earlier, so that echoes from
//   the focal point line up across channels.
//
//   Optional feature macro: APOD_EN
//     Adds a per-channel apodization weight (cfg_weight, Q1.7 unsigned,
//     128 = unity) and one more pipeline stage, for a latency of 2.
//
// Ports
//   clk        rising-edge system clock
//   reset      synchronous, active-high
//   in_valid   din holds a new sample set this cycle
//   din        per-channel input samples, unpacked [0:NUM_CHANNELS-1]
//   cfg_we     write delay (and weight, if enabled) for channel cfg_ch
//   cfg_ch     target channel; writes to channels >= NUM_CHANNELS are dropped
//   cfg_delay  delay in samples, 0..MAX_DELAY-1
//   cfg_weight (APOD_EN only) apodization weight
//   dout       aligned samples, unpacked [0:NUM_CHANNELS-1]
//   out_valid  dout updated this cycle
//   primed     every channel's delay is covered by samples already written
// ---------------------------------------------------------------------------
module delay_align_p #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_DELAY    = 64,
  parameter int DLY_WIDTH    = 6,
  parameter int CH_WIDTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] din [0:NUM_CHANNELS-1],
  input  logic                  cfg_we,
  input  logic [CH_WIDTH-1:0]   cfg_ch,
  input  logic [DLY_WIDTH-1:0]  cfg_delay,
`ifdef APOD_EN
  input  logic [7:0]            cfg_weight,
`endif
  output logic [DATA_WIDTH-1:0] dout [0:NUM_CHANNELS-1],
  output logic                  out_valid,
  output logic                  primed
);

  // The fill counter must reach MAX_DELAY, so it needs one extra bit.
  localparam int FILL_WIDTH = DLY_WIDTH + 1;
  localparam logic [FILL_WIDTH-1:0] FILL_MAX = FILL_WIDTH'(MAX_DELAY);
  localparam logic [FILL_WIDTH-1:0] FILL_ONE = FILL_WIDTH'(1);
  localparam logic [DLY_WIDTH-1:0]  PTR_ONE  = DLY_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] ram_r [0:NUM_CHANNELS-1][0:MAX_DELAY-1];
  logic [DLY_WIDTH-1:0]  wr_ptr_r;
  logic [FILL_WIDTH-1:0] fill_cnt_r;
  logic [FILL_WIDTH-1:0] fill_next_s;
  logic [DLY_WIDTH-1:0]  delay_r      [0:NUM_CHANNELS-1];
  logic [DLY_WIDTH-1:0]  delay_next_s [0:NUM_CHANNELS-1];
  logic [DLY_WIDTH-1:0]  max_delay_s;
  logic [DATA_WIDTH-1:0] sample_s     [0:NUM_CHANNELS-1];
  state_t                state_r;
  state_t                state_s;
  logic                  primed_r;
  logic [DATA_WIDTH-1:0] dout_r       [0:NUM_CHANNELS-1];
  logic                  out_valid_r;

`ifdef APOD_EN
  logic [7:0]            weight_r     [0:NUM_CHANNELS-1];
  logic [DATA_WIDTH-1:0] s1_data_r    [0:NUM_CHANNELS-1];
  logic                  s1_valid_r;

  // Scale by a Q1.7 weight. The shift truncates, and the result saturates
  // when the weight is above unity.
  function automatic logic [DATA_WIDTH-1:0] apply_weight(
    input logic [DATA_WIDTH-1:0] sample,
    input logic [7:0]            weight
  );
    logic [DATA_WIDTH+7:0] prod;
    logic [DATA_WIDTH:0]   scaled;
    prod   = {8'd0, sample} * {{DATA_WIDTH{1'b0}}, weight};
    scaled = prod[DATA_WIDTH+7:7];
    if (scaled[DATA_WIDTH]) begin
      return {DATA_WIDTH{1'b1}};
    end else begin
      return scaled[DATA_WIDTH-1:0];
    end
  endfunction
`endif

  // Delay values that will be in force next cycle. A write to an
  // out-of-range channel matches no index, so it is dropped.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (cfg_we && (32'(cfg_ch) == c)) begin
        delay_next_s[c] = cfg_delay;
      end else begin
        delay_next_s[c] = delay_r[c];
      end
    end
  end

  // Fill count after this cycle's write, saturating at the buffer depth.
  always_comb begin
    if (in_valid && (fill_cnt_r != FILL_MAX)) begin
      fill_next_s = fill_cnt_r + FILL_ONE;
    end else begin
      fill_next_s = fill_cnt_r;
    end
  end

  // Largest delay in force next cycle, used to decide whether all channels are primed.
  always_comb begin
    max_delay_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (delay_next_s[c] > max_delay_s) begin
        max_delay_s = delay_next_s[c];
      end else begin
        max_delay_s = max_delay_s;
      end
    end
  end

  // Next state of the FSM. The state is judged against the fill level and
  // delays that follow this edge, so primed lines up with out_valid.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = (fill_next_s > {1'b0, max_delay_s}) ? ST_RUN : ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL, ST_RUN: begin
        state_s = (fill_next_s > {1'b0, max_delay_s}) ? ST_RUN : ST_FILL;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Select the delayed sample for each channel. Delay 0 bypasses the RAM.
  // A sample that has not been written since reset reads as zero, so stale
  // RAM contents never reach the output.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (delay_r[c] == '0) begin
        sample_s[c] = din[c];
      end else if ({1'b0, delay_r[c]} > fill_cnt_r) begin
        sample_s[c] = '0;
      end else begin
        sample_s[c] = ram_r[c][wr_ptr_r - delay_r[c]];
      end
    end
  end

  // Sample buffer write. It has no reset; fill_cnt masks stale contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!reset && in_valid) begin
        ram_r[c][wr_ptr_r] <= din[c];
      end
    end
  end

  // Write pointer, fill level, delay table, FSM state and primed flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      state_r    <= ST_IDLE;
      primed_r   <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        delay_r[c] <= '0;
      end
    end else begin
      if (in_valid) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      fill_cnt_r <= fill_next_s;
      state_r    <= state_s;
      primed_r   <= (state_s == ST_RUN);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        delay_r[c] <= delay_next_s[c];
      end
    end
  end

`ifdef APOD_EN
  // Weight table, written alongside the delay; resets to unity.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        weight_r[c] <= 8'd128;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (cfg_we && (32'(cfg_ch) == c)) begin
          weight_r[c] <= cfg_weight;
        end
      end
    end
  end

  // Two-stage output: the delayed sample is registered, then the weight is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        s1_data_r[c] <= '0;
        dout_r[c]    <= '0;
      end
    end else begin
      s1_valid_r  <= in_valid;
      out_valid_r <= s1_valid_r;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (in_valid) begin
          s1_data_r[c] <= sample_s[c];
        end
        if (s1_valid_r) begin
          dout_r[c] <= apply_weight(s1_data_r[c], weight_r[c]);
        end
      end
    end
  end
`else
  // Single-stage output register. It holds its value between valid cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        dout_r[c] <= '0;
      end
    end else begin
      out_valid_r <= in_valid;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (in_valid) begin
          dout_r[c] <= sample_s[c];
        end
      end
    end
  end
`endif

  assign dout      = dout_r;
  assign out_valid = out_valid_r;
  assign primed    = primed_r;

endmodule
